axi_sha_master: RTL

//  AXI4 burst initiator driving the SHA AXI slave (axi_ip). On start, writes WR_BEATS message

---
 rtl/axi_sha_if.sv | 67 ++++++
 rtl/axi_sha_master.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/axi_sha_if.sv
// AXI4 channel bundle between the SHA burst initiator (master) and the SHA slave.
interface axi_sha_if;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [7:0]          AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;

  logic [ID_W-1:0]     WID;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;

  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;

  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [7:0]          ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;

  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi_sha_master.sv
// AXI4 burst initiator for the SHA slave: writes a message burst, waits for the hash core,
// reads the digest burst back and streams the digest words out.
module axi_sha_master #(
  parameter int unsigned WR_BEATS = 50,
  parameter int unsigned RD_BEATS = 8,
  parameter logic [31:0] WR_ADDR  = 32'h0000_0100,
  parameter logic [31:0] RD_ADDR  = 32'h0000_0010,
  parameter int unsigned RD_DELAY = 400
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        src_valid,
  input  logic [31:0] src_data,
  output logic        src_ready,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [7:0]  res_idx,
  axi_sha_if.master   axi
);
  localparam int unsigned CNT_W = 9;
  localparam int unsigned DLY_W = (RD_DELAY < 2) ? 1 : $clog2(RD_DELAY + 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_BEATS - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_DLY, S_AR, S_R, S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] sent;
  logic [CNT_W-1:0] wbeat;
  logic [CNT_W-1:0] rbeat;
  logic [DLY_W-1:0] dly_cnt;
  logic             src_hs;
  logic             w_hs;
  logic             unused_ids;

  // Burst attributes that never vary.
  assign axi.AWID    = '0;
  assign axi.WID     = '0;
  assign axi.ARID    = '0;
  assign axi.AWSIZE  = 3'b010;
  assign axi.ARSIZE  = 3'b010;
  assign axi.AWBURST = 2'b01;
  assign axi.ARBURST = 2'b01;
  assign axi.WSTRB   = 4'hF;
  assign unused_ids  = ^{axi.BID, axi.RID};

  // The W register may refill whenever it is empty or being drained this cycle.
  assign src_ready = (state == S_W) && (!axi.WVALID || axi.WREADY)
                     && (sent < CNT_W'(WR_BEATS));
  assign src_hs    = src_valid && src_ready;
  assign w_hs      = axi.WVALID && axi.WREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_idx     <= '0;
      sent        <= '0;
      wbeat       <= '0;
      rbeat       <= '0;
      dly_cnt     <= '0;
      axi.AWVALID <= 1'b0;
      axi.AWADDR  <= '0;
      axi.AWLEN   <= '0;
      axi.WVALID  <= 1'b0;
      axi.WDATA   <= '0;
      axi.WLAST   <= 1'b0;
      axi.BREADY  <= 1'b0;
      axi.ARVALID <= 1'b0;
      axi.ARADDR  <= '0;
      axi.ARLEN   <= '0;
      axi.RREADY  <= 1'b0;
    end else begin
      done      <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_AW;
            busy        <= 1'b1;
            err         <= 1'b0;
            sent        <= '0;
            wbeat       <= '0;
            rbeat       <= '0;
            dly_cnt     <= '0;
            axi.AWVALID <= 1'b1;
            axi.AWADDR  <= WR_ADDR;
            axi.AWLEN   <= 8'(WR_BEATS - 1);
          end
        end
        S_AW: begin
          if (axi.AWREADY) begin
            state       <= S_W;
            axi.AWVALID <= 1'b0;
            axi.AWADDR  <= '0;
            axi.AWLEN   <= '0;
          end
        end
        S_W: begin
          if (src_hs) begin
            axi.WDATA  <= src_data;
            axi.WVALID <= 1'b1;
            axi.WLAST  <= (sent == WR_LAST);
            sent       <= sent + 1'b1;
          end else if (w_hs) begin
            axi.WVALID <= 1'b0;
            axi.WLAST  <= 1'b0;
          end
          if (w_hs) begin
            wbeat <= wbeat + 1'b1;
            if (wbeat == WR_LAST) begin
              state      <= S_B;
              axi.BREADY <= 1'b1;
            end
          end
        end
        S_B: begin
          if (axi.BVALID) begin
            state      <= S_DLY;
            axi.BREADY <= 1'b0;
            dly_cnt    <= '0;
            if (axi.BRESP != 2'b00) err <= 1'b1;
          end
        end
        S_DLY: begin
          if (dly_cnt == DLY_W'(RD_DELAY)) begin
            state       <= S_AR;
            axi.ARVALID <= 1'b1;
            axi.ARADDR  <= RD_ADDR;
            axi.ARLEN   <= 8'(RD_BEATS - 1);
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        S_AR: begin
          if (axi.ARREADY) begin
            state       <= S_R;
            axi.ARVALID <= 1'b0;
            axi.ARADDR  <= '0;
            axi.ARLEN   <= '0;
            axi.RREADY  <= 1'b1;
          end
        end
        S_R: begin
          // Burst length is set by our own count; RLAST is only cross-checked.
          if (axi.RVALID) begin
            res_valid <= 1'b1;
            res_data  <= axi.RDATA;
            res_idx   <= rbeat[7:0];
            rbeat     <= rbeat + 1'b1;
            if ((axi.RRESP != 2'b00) || (axi.RLAST != (rbeat == RD_LAST))) err <= 1'b1;
            if (rbeat == RD_LAST) begin
              state      <= S_DONE;
              axi.RREADY <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
